// File: rtl/spi_reg_ctrl_if.sv
// Register-file bus between the SPI command sequencer (master) and the
// register file (slave). One request (write or read) is outstanding at a time.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
) ();
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              reg_ack;

    modport master (
        output reg_addr, reg_wdata, reg_we, reg_re,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_addr, reg_wdata, reg_we, reg_re,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: synchronises the SPI slave's SS and byte-activity
// flag into the system clock domain, decodes a command byte, and runs single
// or auto-incrementing burst reads/writes on the register bus. Read data is
// fed to the slave's transmit byte so it appears on MISO one byte after the
// turnaround byte.
module spi_reg_ctrl #(
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           spi_ss,
    input  logic [7:0]     spi_rx_byte,
    input  logic           spi_receiveing,
    output logic [7:0]     spi_tx_byte,
    spi_reg_ctrl_if.master reg_bus,
    input  logic           err_clr,
    output logic           busy,
    output logic           overrun
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WRITE,
        READ
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] ssSync_q;
    logic                   ssPrev_q;
    logic [SYNC_STAGES-1:0] rcvSync_q;
    logic                   rcvPrev_q;
    logic                   inByte_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [7:0]             wdata_q;
    logic                   we_q;
    logic                   re_q;
    logic [7:0]             rdBuf_q;
    logic                   rdValid_q;
    logic                   copied_q;
    logic [7:0]             txByte_q;
    logic                   overrun_q;

    logic                   ss_s;
    logic                   rcv_s;
    logic                   byteStart;
    logic                   byteDone;
    logic                   ssFall;
    logic                   ssRise;
    logic [ADDR_W-1:0]      addrNext_d;

    // Edge detection on the synchronised SPI-domain flags, and the next burst address
    always_comb begin
        ss_s       = ssSync_q[SYNC_STAGES-1];
        rcv_s      = rcvSync_q[SYNC_STAGES-1];
        byteStart  = rcv_s & ~rcvPrev_q & ~ss_s;
        byteDone   = ~rcv_s & rcvPrev_q & ~ss_s;
        ssFall     = ssPrev_q & ~ss_s;
        ssRise     = ~ssPrev_q & ss_s;
        addrNext_d = addr_q + ADDR_W'(1);
    end

    // Synchronisers, bus request handshake and the command/burst state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ssSync_q  <= '1;
            ssPrev_q  <= 1'b1;
            rcvSync_q <= '0;
            rcvPrev_q <= 1'b0;
            inByte_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            rdBuf_q   <= 8'h00;
            rdValid_q <= 1'b0;
            copied_q  <= 1'b0;
            txByte_q  <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            ssSync_q  <= {ssSync_q[SYNC_STAGES-2:0], spi_ss};
            ssPrev_q  <= ss_s;
            rcvSync_q <= {rcvSync_q[SYNC_STAGES-2:0], spi_receiveing};
            rcvPrev_q <= rcv_s;

            if (byteStart) begin
                inByte_q <= 1'b1;
                copied_q <= 1'b0;
            end else if (byteDone || ss_s) begin
                inByte_q <= 1'b0;
            end

            // Clear first so that a simultaneous new overrun event below wins
            if (err_clr) begin
                overrun_q <= 1'b0;
            end

            if (we_q && reg_bus.reg_ack) begin
                we_q   <= 1'b0;
                addr_q <= addrNext_d;
            end

            // Read data is only kept while the burst that asked for it is still live
            if (re_q && reg_bus.reg_ack) begin
                re_q <= 1'b0;
                if (state_q == READ && !ssRise) begin
                    rdBuf_q   <= reg_bus.reg_rdata;
                    rdValid_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    txByte_q <= {7'b0, overrun_q};
                    if (ssFall) begin
                        state_q <= CMD;
                    end
                end
                CMD: begin
                    if (byteDone) begin
                        addr_q <= spi_rx_byte[ADDR_W-1:0];
                        if (spi_rx_byte[7]) begin
                            re_q    <= 1'b1;
                            state_q <= READ;
                        end else begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (byteDone) begin
                        if (we_q) begin
                            overrun_q <= 1'b1;
                        end else begin
                            wdata_q <= spi_rx_byte;
                            we_q    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (inByte_q && rdValid_q && !copied_q) begin
                        txByte_q  <= rdBuf_q;
                        copied_q  <= 1'b1;
                        rdValid_q <= 1'b0;
                        addr_q    <= addrNext_d;
                        re_q      <= 1'b1;
                    end
                    if (byteDone && !copied_q) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // SS release ends the transaction; a pending request still completes on its own
            if (ssRise) begin
                state_q   <= IDLE;
                rdValid_q <= 1'b0;
                copied_q  <= 1'b0;
            end
        end
    end

    assign spi_tx_byte       = txByte_q;
    assign overrun           = overrun_q;
    assign busy              = (state_q != IDLE) | we_q | re_q;
    assign reg_bus.reg_addr  = addr_q;
    assign reg_bus.reg_wdata = wdata_q;
    assign reg_bus.reg_we    = we_q;
    assign reg_bus.reg_re    = re_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Testbench for spi_reg_ctrl: an SPI master model drives byte frames, a
// register-file responder acknowledges bus requests, and two monitors compare
// bus requests and MISO bytes against expectations queued by the stimulus.
module tb_spi_reg_ctrl;

    localparam int ADDR_W   = 7;
    localparam int SCLK_DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_ss = 1'b1;
    logic [7:0] spi_rx_byte = 8'h00;
    logic       spi_receiveing = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] spi_tx_byte;
    logic       busy;
    logic       overrun;

    spi_reg_ctrl_if #(.ADDR_W(ADDR_W)) regBus ();

    spi_reg_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi_ss         (spi_ss),
        .spi_rx_byte    (spi_rx_byte),
        .spi_receiveing (spi_receiveing),
        .spi_tx_byte    (spi_tx_byte),
        .reg_bus        (regBus.master),
        .err_clr        (err_clr),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         isWrite;
        logic [6:0] addr;
        logic [7:0] data;
    } busEv_t;

    int         total = 0;
    int         bad = 0;
    busEv_t     expBus[$];
    logic [7:0] expMiso[$];
    logic [7:0] frameBytes[$];
    logic [7:0] payload[$];
    logic [7:0] refMem[128];
    logic [7:0] regFile[128];
    int         ackLat = 2;
    bit         busCheckOn = 1'b1;
    bit         misoCheckOn = 1'b0;
    bit         expOverrun = 1'b0;
    int         frameLen = 0;
    int         byteIdx = 0;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    // One SPI byte: activity flag high for 7 SCLK periods, then low with the byte latched
    task automatic sendByte(input logic [7:0] b);
        spi_receiveing = 1'b1;
        repeat (7 * SCLK_DIV) @(negedge clk);
        spi_rx_byte    = b;
        spi_receiveing = 1'b0;
        repeat (SCLK_DIV) @(negedge clk);
    endtask

    // A full SS-framed transfer of frameBytes
    task automatic runFrame();
        byteIdx  = 0;
        frameLen = frameBytes.size();
        @(negedge clk);
        spi_ss = 1'b0;
        repeat (8) @(negedge clk);
        foreach (frameBytes[i]) sendByte(frameBytes[i]);
        repeat (4) @(negedge clk);
        spi_ss = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Builds a transaction, queues the expected bus requests and MISO bytes, then runs it
    task automatic applyStimulus(input bit isRead, input logic [6:0] startAddr, input int nData, input int lat);
        logic [6:0] a;
        busEv_t     ev;
        ackLat = lat;
        frameBytes.delete();
        frameBytes.push_back({isRead, startAddr});
        if (isRead) begin
            misoCheckOn = 1'b1;
            expMiso.push_back({7'b0, expOverrun});
            for (int i = 0; i <= nData; i++) begin
                a = 7'((int'(startAddr) + i) % 128);
                ev.isWrite = 1'b0;
                ev.addr    = a;
                ev.data    = 8'h00;
                expBus.push_back(ev);
                if (i < nData) frameBytes.push_back(8'($urandom));
                if (i < nData - 1) expMiso.push_back(refMem[a]);
            end
        end else begin
            misoCheckOn = 1'b0;
            for (int i = 0; i < nData; i++) begin
                a = 7'((int'(startAddr) + i) % 128);
                ev.isWrite = 1'b1;
                ev.addr    = a;
                ev.data    = payload[i];
                expBus.push_back(ev);
                refMem[a] = payload[i];
                frameBytes.push_back(payload[i]);
            end
        end
        runFrame();
        checkOutput("busDrained", expBus.size(), 0);
        if (isRead) checkOutput("misoDrained", expMiso.size(), 0);
        misoCheckOn = 1'b0;
    endtask

    // Register-file responder and bus-request monitor
    initial begin
        busEv_t got;
        busEv_t e;
        regBus.reg_ack   = 1'b0;
        regBus.reg_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && (regBus.reg_we || regBus.reg_re)) begin
                got.isWrite = regBus.reg_we;
                got.addr    = regBus.reg_addr;
                got.data    = regBus.reg_wdata;
                if (busCheckOn) begin
                    if (expBus.size() == 0) begin
                        checkOutput("busUnexpected", {got.isWrite, 1'b0, got.addr}, 0);
                    end else begin
                        e = expBus.pop_front();
                        checkOutput("busKind", got.isWrite, e.isWrite);
                        checkOutput("busAddr", got.addr, e.addr);
                        if (e.isWrite) checkOutput("busWdata", got.data, e.data);
                    end
                end
                repeat (ackLat - 1) @(negedge clk);
                if (rst_n && (regBus.reg_we || regBus.reg_re)) begin
                    if (regBus.reg_we) regFile[got.addr] = got.data;
                    regBus.reg_rdata = regFile[got.addr];
                    regBus.reg_ack   = 1'b1;
                    @(negedge clk);
                    regBus.reg_ack   = 1'b0;
                end
            end
        end
    end

    // MISO monitor: the slave loads spi_tx_byte when the activity flag falls
    initial begin
        forever begin
            @(negedge spi_receiveing);
            if (misoCheckOn && !spi_ss && byteIdx < frameLen - 1) begin
                if (expMiso.size() == 0) begin
                    checkOutput("misoUnexpected", spi_tx_byte, 32'hFFFF_FFFF);
                end else begin
                    checkOutput($sformatf("misoByte%0d", byteIdx + 1), spi_tx_byte, expMiso.pop_front());
                end
            end
            if (!spi_ss) byteIdx++;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #800000;
        bad++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int         waitCnt;
        busEv_t     ev;
        logic [6:0] ra;
        int         rn;

        for (int i = 0; i < 128; i++) begin
            refMem[i]  = 8'($urandom);
            regFile[i] = refMem[i];
        end

        $display("[TB] reset values");
        repeat (3) @(negedge clk);
        checkOutput("rstTx", spi_tx_byte, 8'h00);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstOverrun", overrun, 0);
        checkOutput("rstWe", regBus.reg_we, 0);
        checkOutput("rstRe", regBus.reg_re, 0);
        checkOutput("rstAddr", regBus.reg_addr, 0);
        checkOutput("rstWdata", regBus.reg_wdata, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] write burst at 0x05");
        payload = '{8'h3C, 8'h7E};
        applyStimulus(1'b0, 7'h05, 2, 2);
        checkOutput("wrOverrun", overrun, 0);

        $display("[TB] read burst at 0x05");
        refMem[5] = 8'h11; regFile[5] = 8'h11;
        refMem[6] = 8'h22; regFile[6] = 8'h22;
        applyStimulus(1'b1, 7'h05, 3, 2);

        $display("[TB] address wrap");
        payload = '{8'hAA, 8'hBB};
        applyStimulus(1'b0, 7'h7F, 2, 3);

        $display("[TB] randomized bursts");
        for (int k = 0; k < 6; k++) begin
            payload.delete();
            rn = $urandom_range(4, 1);
            for (int i = 0; i < rn; i++) payload.push_back(8'($urandom));
            applyStimulus(1'b0, 7'($urandom), rn, $urandom_range(6, 1));
            ra = (k % 2 == 0) ? 7'($urandom) : 7'h7E;
            applyStimulus(1'b1, ra, $urandom_range(4, 1), $urandom_range(8, 1));
        end
        checkOutput("randOverrun", overrun, 0);

        $display("[TB] slow bus read");
        busCheckOn  = 1'b0;
        misoCheckOn = 1'b0;
        ackLat      = 100;
        frameBytes  = '{8'h85, 8'h00, 8'h00, 8'h00};
        runFrame();
        checkOutput("slowOverrun", overrun, 1);
        waitCnt = 0;
        while (busy && waitCnt < 400) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("slowDrainTimeout", busy, 0);
        busCheckOn = 1'b1;
        expOverrun = 1'b1;
        applyStimulus(1'b1, 7'h20, 2, 2);

        $display("[TB] abort with read pending");
        ackLat      = 30;
        misoCheckOn = 1'b0;
        ev.isWrite  = 1'b0;
        ev.addr     = 7'h10;
        ev.data     = 8'h00;
        expBus.push_back(ev);
        @(negedge clk);
        spi_ss = 1'b0;
        repeat (8) @(negedge clk);
        sendByte(8'h90);
        waitCnt = 0;
        while (!regBus.reg_re && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("abortReqSeen", regBus.reg_re, 1);
        spi_ss = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("abortReqHeld", regBus.reg_re, 1);
        checkOutput("abortBusyPending", busy, 1);
        waitCnt = 0;
        while (regBus.reg_re && waitCnt < 60) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("abortReqDrop", regBus.reg_re, 0);
        repeat (2) @(negedge clk);
        checkOutput("abortIdle", busy, 0);
        checkOutput("abortAddr", regBus.reg_addr, 7'h10);
        checkOutput("abortStatus", spi_tx_byte, {7'b0, expOverrun});
        checkOutput("abortDrained", expBus.size(), 0);

        $display("[TB] overrun clear");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("errClr", overrun, 0);
        expOverrun = 1'b0;
        @(negedge clk);
        checkOutput("statusAfterClr", spi_tx_byte, 8'h00);

        $display("[TB] reset during write");
        ackLat     = 20;
        ev.isWrite = 1'b1;
        ev.addr    = 7'h30;
        ev.data    = 8'h55;
        expBus.push_back(ev);
        @(negedge clk);
        spi_ss = 1'b0;
        repeat (8) @(negedge clk);
        sendByte(8'h30);
        sendByte(8'h55);
        waitCnt = 0;
        while (!regBus.reg_we && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("rstWrSeen", regBus.reg_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstWe", regBus.reg_we, 0);
        checkOutput("asyncRstBusy", busy, 0);
        checkOutput("asyncRstTx", spi_tx_byte, 8'h00);
        @(negedge clk);
        spi_ss = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("finalBusDrained", expBus.size(), 0);
        checkOutput("finalMisoDrained", expMiso.size(), 0);
        checkOutput("finalIdle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
